dut_fsm_chain_checker: RTL and testbench
========================================

# dut_fsm_chain_checker

Stimulus generator and response checker for the DUT FSM chain under TMR/SEU test. It drives a pseudo-random word stream into the chain input and compares the chain output against a delayed copy of the same stream. Mismatches are counted and flagged for readout by the test-system control logic. The block sits on the opposite side of the chain: its `stim_o` feeds the chain `data_i`, and the chain `data_o` feeds `resp_i`.

## Interface
- `IO_SIZE_G`, 4: word width; legal range 1..16.
- `LATENCY_G`, 16: chain latency in clock cycles (one cycle per FSM stage); legal range 1..256.
- `CNT_W_G`, 16: width of the error and word counters.

Ports:
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  one-cycle pulse; begins a run from IDLE.
- `stop_i`  in  1  one-cycle pulse; ends the run and returns to IDLE.
- `clear_i`  in  1  clears counters and the sticky flag; honoured in any state.
- `stim_o`  out  IO_SIZE_G  stimulus word to the chain input.
- `resp_i`  in  IO_SIZE_G  response word from the chain output.
- `running_o`  out  1  high while the state is FLUSH or CHECK.
- `error_o`  out  1  sticky; set on the first mismatch.
- `err_cnt_o`  out  CNT_W_G  mismatch count; saturates at all-ones.
- `word_cnt_o`  out  CNT_W_G  count of compared words; saturates at all-ones.

## Operation
- **LFSR**
  - 16-bit Fibonacci LFSR with seed 16'hACE1.
  - Each step shifts left; the new bit 0 is lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
  - The LFSR is held at the seed in IDLE and steps once per cycle in FLUSH and CHECK.
- **Stimulus:** registered. `stim_o` <= lfsr[IO_SIZE_G-1:0] in FLUSH/CHECK and 0 in IDLE.
- **Expected delay line**
  - LATENCY_G registers, each IO_SIZE_G wide, fed from `stim_o`.
  - The tail of the line is compared with `resp_i`.
  - The line is cleared to 0 on reset and on entry to FLUSH.
- **FSM states:** IDLE, FLUSH, CHECK.
  - IDLE -> FLUSH on `start_i`; the flush counter loads LATENCY_G.
  - FLUSH -> CHECK when the flush counter reaches 0. The counter decrements each cycle, so FLUSH lasts exactly LATENCY_G+1 cycles: LATENCY_G for the chain plus 1 for the stim register.
  - FLUSH/CHECK -> IDLE on `stop_i`. `stop_i` has priority over the FLUSH->CHECK transition.
  - `start_i` is ignored outside IDLE.
- **CHECK comparison:** every cycle, compare `resp_i` against the delay-line tail.
  - Increment `word_cnt_o`.
  - On inequality, increment `err_cnt_o` and set `error_o`.
  - Both counters saturate and do not wrap.
- **`clear_i`**
  - Zeroes both counters and `error_o`, without changing state.
  - If a mismatch occurs in the same cycle as `clear_i`, `clear_i` wins: the result is count 0, flag 0.
- **Simultaneous `start_i` and `stop_i` in IDLE:** stay in IDLE.
- **Reset mid-run:** asynchronous return to IDLE with all registers at their reset values.

## Timing
- **Reset values:**
  - `stim_o` = 0, `running_o` = 0, `error_o` = 0, `err_cnt_o` = 0, `word_cnt_o` = 0.
  - State is IDLE, the LFSR is at the seed, and the delay line is all zeros.
- **Cycle 0:** `start_i` is sampled high.
- **Cycle 1:** `running_o` = 1, and `stim_o` still shows 0. The first LFSR word appears on `stim_o` at cycle 2.
- **First compare:** at cycle LATENCY_G+2, against the first LFSR word, assuming `resp_i` = `stim_o` delayed LATENCY_G cycles.
- **Counter/flag latency:** counters and `error_o` update one cycle after the compare cycle.
- **After a stop:** `stop_i` at cycle N gives `running_o` = 0 and `stim_o` = 0 at N+1. No compare occurs at N+1.

## Configuration
- **`DUT_CHECKER_ERR_INJECT_EN`**
  - With the macro defined, the block adds the port `inject_i`  in  1. When `inject_i` is high during FLUSH/CHECK, stim_o[0] is inverted for that one word only, and the delay line receives the uninverted word. The result is exactly one mismatch LATENCY_G+1 cycles later.
  - Without the macro, the port is absent and the stimulus is never altered.

## Test plan
- **Loopback run:** IO_SIZE_G=4, LATENCY_G=16, `resp_i` = `stim_o` through a 16-register ideal delay, run 1000 cycles, then stop.
  - Required: `err_cnt_o` = 0, `error_o` = 0, `word_cnt_o` = 1000-18.
  - The first `stim_o` word is 4'h1 (low nibble of seed 16'hACE1).
- **Single corruption:** same setup, invert `resp_i`[2] for one CHECK cycle.
  - Required: `err_cnt_o` = 1, and `error_o` rises one cycle later and stays high.
- **Saturation:** CNT_W_G=4, `resp_i` tied to 4'hF for 40 CHECK cycles.
  - Required: `err_cnt_o` holds at 4'hF and does not wrap.
- **Clear vs. mismatch:** `clear_i` in the same cycle as a mismatch.
  - Required: counters = 0, `error_o` = 0, state remains CHECK.
- **Reset mid-run:** deassert `rst_ni` during CHECK.
  - Required: all outputs go to 0 immediately. A subsequent `start_i` reproduces the same first word, 4'h1.
- **Inject (macro defined):** pulse `inject_i` once during CHECK.
  - Required: exactly one error, counted LATENCY_G+2 cycles after the pulse.

Source files
------------

// File: rtl/dut_fsm_chain_checker.sv
// dut_fsm_chain_checker: LFSR stimulus generator and delayed-compare response checker for the DUT FSM chain.
// Ports:
//   clk_i, rst_ni (async, active-low)      clock and reset
//   start_i / stop_i                        one-cycle run control pulses
//   clear_i                                 zero counters and sticky error flag
//   stim_o [IO_SIZE_G]                      stimulus word to chain data_i
//   resp_i [IO_SIZE_G]                      response word from chain data_o
//   running_o                               high in FLUSH or CHECK
//   error_o                                 sticky mismatch flag
//   err_cnt_o / word_cnt_o [CNT_W_G]        saturating mismatch / compared-word counters
//   inject_i                                only with DUT_CHECKER_ERR_INJECT_EN: flip stim_o[0] for one word
module dut_fsm_chain_checker #(
  parameter int IO_SIZE_G = 4,
  parameter int LATENCY_G = 16,
  parameter int CNT_W_G   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 clear_i,
`ifdef DUT_CHECKER_ERR_INJECT_EN
  input  logic                 inject_i,
`endif
  output logic [IO_SIZE_G-1:0] stim_o,
  input  logic [IO_SIZE_G-1:0] resp_i,
  output logic                 running_o,
  output logic                 error_o,
  output logic [CNT_W_G-1:0]   err_cnt_o,
  output logic [CNT_W_G-1:0]   word_cnt_o
);
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int FW = $clog2(LATENCY_G + 1);
  typedef enum logic [1:0] {IDLE, FLUSH, CHECK} state_t;
  state_t state;
  logic [FW-1:0] flush_cnt;
  logic [15:0] lfsr;
  logic [IO_SIZE_G-1:0] stim_q;
  logic [IO_SIZE_G-1:0] dl [LATENCY_G];
  logic inj, enter, step, mismatch;
`ifdef DUT_CHECKER_ERR_INJECT_EN
  assign inj = inject_i;
`else
  assign inj = 1'b0;
`endif
  assign enter    = state == IDLE && start_i && !stop_i;
  assign step     = state != IDLE && !stop_i;
  assign mismatch = resp_i != dl[LATENCY_G-1];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state      <= IDLE;
      running_o  <= 1'b0;
      flush_cnt  <= '0;
      lfsr       <= SEED;
      stim_q     <= '0;
      stim_o     <= '0;
      error_o    <= 1'b0;
      err_cnt_o  <= '0;
      word_cnt_o <= '0;
      for (int i = 0; i < LATENCY_G; i++) dl[i] <= '0;
    end else begin
      if (state == IDLE) begin
        state     <= enter ? FLUSH : IDLE;
        running_o <= enter;
        flush_cnt <= FW'(LATENCY_G);
      end else if (stop_i) begin
        state     <= IDLE;
        running_o <= 1'b0;
      end else if (state == FLUSH) begin
        if (flush_cnt == '0) state <= CHECK;
        else flush_cnt <= flush_cnt - FW'(1);
      end
      lfsr   <= step ? {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]} : SEED;
      stim_q <= step ? lfsr[IO_SIZE_G-1:0] : '0;
      // injected flip reaches the chain only; the delay line keeps the clean word so the flip shows as one mismatch
      stim_o <= step ? lfsr[IO_SIZE_G-1:0] ^ IO_SIZE_G'(inj) : '0;
      dl[0]  <= enter ? '0 : stim_q;
      for (int i = 1; i < LATENCY_G; i++) dl[i] <= enter ? '0 : dl[i-1];
      if (clear_i) begin
        error_o    <= 1'b0;
        err_cnt_o  <= '0;
        word_cnt_o <= '0;
      end else if (state == CHECK) begin
        word_cnt_o <= word_cnt_o + CNT_W_G'(word_cnt_o != '1);
        err_cnt_o  <= err_cnt_o + CNT_W_G'(mismatch && err_cnt_o != '1);
        error_o    <= error_o | mismatch;
      end
    end
endmodule

// File: tb/tb_dut_fsm_chain_checker.sv
// tb_dut_fsm_chain_checker: randomized bench with a word-history reference model of the chain checker.
module tb_dut_fsm_chain_checker;
  localparam int W = 4;
  localparam int L = 16;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, inject = 1'b0;
  logic [W-1:0] stim, stim2, resp = '0;
  logic running, running2, error, error2;
  logic [15:0] err_cnt, word_cnt;
  logic [3:0] err2, words2;
  int total = 0, bad = 0;
  bit m_run, m_flag, m_flag2;
  int m_k, m_err, m_words, m_err2, m_words2;
  logic [15:0] m_lfsr;
  logic [W-1:0] m_stim, m_clean;
  logic [W-1:0] chain_q[$], clean_q[$];
  always #5 clk = ~clk;
  dut_fsm_chain_checker #(.IO_SIZE_G(W), .LATENCY_G(L), .CNT_W_G(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop), .clear_i(clear),
`ifdef DUT_CHECKER_ERR_INJECT_EN
    .inject_i(inject),
`endif
    .stim_o(stim), .resp_i(resp), .running_o(running), .error_o(error),
    .err_cnt_o(err_cnt), .word_cnt_o(word_cnt));
  dut_fsm_chain_checker #(.IO_SIZE_G(W), .LATENCY_G(L), .CNT_W_G(4)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop), .clear_i(clear),
`ifdef DUT_CHECKER_ERR_INJECT_EN
    .inject_i(inject),
`endif
    .stim_o(stim2), .resp_i(4'hF), .running_o(running2), .error_o(error2),
    .err_cnt_o(err2), .word_cnt_o(words2));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_run = 0; m_k = 0; m_lfsr = 16'hACE1; m_stim = '0; m_clean = '0;
    m_err = 0; m_words = 0; m_flag = 0; m_err2 = 0; m_words2 = 0; m_flag2 = 0;
    chain_q = {}; clean_q = {};
    repeat (L) begin chain_q.push_back('0); clean_q.push_back('0); end
  endtask
  // one clock cycle: check outputs, present inputs, advance the model, move to the next falling edge
  task automatic cyc(input bit st, input bit sp, input bit cl, input bit inj, input logic [W-1:0] mask);
    logic [W-1:0] tail, r;
    bit cmp;
    check("stim", stim, m_stim);
    check("stim_sat", stim2, m_stim);
    check("running", running, m_run);
    check("running_sat", running2, m_run);
    check("error", error, m_flag);
    check("err_cnt", err_cnt, m_err);
    check("word_cnt", word_cnt, m_words);
    check("error_sat", error2, m_flag2);
    check("err_sat", err2, m_err2);
    check("words_sat", words2, m_words2);
    chain_q.push_back(stim);
    r = chain_q.pop_front() ^ mask;
    clean_q.push_back(m_clean);
    tail = clean_q.pop_front();
    resp = r; start = st; stop = sp; clear = cl; inject = inj;
    cmp = m_run && m_k >= L + 2;
    if (cl) begin
      m_err = 0; m_words = 0; m_flag = 0; m_err2 = 0; m_words2 = 0; m_flag2 = 0;
    end else if (cmp) begin
      if (m_words < 65535) m_words++;
      if (r != tail) begin if (m_err < 65535) m_err++; m_flag = 1; end
      if (m_words2 < 15) m_words2++;
      if (tail != 4'hF) begin if (m_err2 < 15) m_err2++; m_flag2 = 1; end
    end
    if (!m_run || sp) begin
      if (!m_run && st && !sp) begin m_run = 1; m_k = 1; end
      else m_run = 0;
      m_stim = '0; m_clean = '0; m_lfsr = 16'hACE1;
    end else begin
      m_k++;
      m_clean = m_lfsr[W-1:0];
      m_stim = m_clean;
`ifdef DUT_CHECKER_ERR_INJECT_EN
      m_stim[0] = m_stim[0] ^ inj;
`endif
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, '0);
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_stim", stim, 0);
    check("rst_running", running, 0);
    check("rst_error", error, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_word_cnt", word_cnt, 0);
    rst_n = 1'b1;
    // loopback run: start at cycle 0, stop at cycle 999
    cyc(1, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, '0);
    check("first_word", stim, 4'h1);
    idle(997);
    cyc(0, 1, 0, 0, '0);
    idle(1);
    check("loop_err_cnt", err_cnt, 0);
    check("loop_error", error, 0);
    check("loop_word_cnt", word_cnt, 1000 - 18);
    check("loop_running", running, 0);
    check("sat_err_hold", err2, 4'hF);
    // single corruption of resp bit 2
    cyc(1, 0, 0, 0, '0);
    idle(L + 10);
    check("corr_error_before", error, 0);
    cyc(0, 0, 0, 0, 4'h4);
    check("corr_error_after", error, 1);
    idle(5);
    check("corr_err_cnt", err_cnt, 1);
    check("corr_error_sticky", error, 1);
    cyc(0, 1, 0, 0, '0);
    // clear in the same cycle as a mismatch
    cyc(1, 0, 0, 0, '0);
    idle(L + 6);
    cyc(0, 0, 1, 0, 4'h2);
    check("clr_err_cnt", err_cnt, 0);
    check("clr_word_cnt", word_cnt, 0);
    check("clr_error", error, 0);
    check("clr_running", running, 1);
    idle(3);
    cyc(1, 1, 0, 0, '0);
    cyc(0, 1, 0, 0, '0);
    // start with stop in IDLE must stay idle
    cyc(1, 1, 0, 0, '0);
    check("start_stop_idle", running, 0);
    // asynchronous reset mid-run
    cyc(1, 0, 0, 0, '0);
    idle(L + 8);
    cyc(0, 0, 0, 0, 4'h8);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_stim", stim, 0);
    check("mid_rst_running", running, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    check("mid_rst_word_cnt", word_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc(1, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, '0);
    check("restart_first_word", stim, 4'h1);
    idle(L + 4);
`ifdef DUT_CHECKER_ERR_INJECT_EN
    cyc(0, 0, 1, 0, '0);
    idle(2);
    cyc(0, 0, 0, 1, '0);
    idle(L);
    check("inj_before", err_cnt, 0);
    idle(1);
    check("inj_after", err_cnt, 1);
    idle(4);
    check("inj_exactly_one", err_cnt, 1);
`endif
    // randomized control and corruption
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 199) == 0, $urandom_range(0, 149) == 0,
          $urandom_range(0, 99) == 0, ($urandom_range(0, 39) == 0) ? W'($urandom_range(1, 15)) : '0);
    cyc(0, 1, 0, 0, '0);
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
